// File: rtl/spi_dbg_pkg.sv
// Shared constants for the debug SPI command protocol: command and reply
// bytes, the host FSM state encoding and the per-state transmit byte.
package spi_dbg_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_LED   = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'hCC;
  localparam logic [7:0] CMD_ECHO  = 8'hCD;

  localparam logic [7:0] RSP_READY = 8'hFF;
  localparam logic [7:0] RSP_BUSY  = 8'hFE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR0 = 3'd2;
  localparam logic [2:0] S_ADDR1 = 3'd3;
  localparam logic [2:0] S_ADDR2 = 3'd4;
  localparam logic [2:0] S_POLL  = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Byte the host shifts out while sitting in a given byte state.
  function automatic logic [7:0] tx_byte(input logic [2:0] st, input logic [23:0] addr);
    logic [7:0] b;
    b = CMD_NOP;
    case (st)
      S_CMD:   b = CMD_READ;
      S_ADDR0: b = addr[23:16];
      S_ADDR1: b = addr[15:8];
      S_ADDR2: b = addr[7:0];
      default: b = CMD_NOP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_master_byte.sv
// SPI mode-0 byte engine: one start pulse shifts one byte out on mosi (MSB
// first) while shifting one byte in from miso. sclk idles low; miso is
// sampled through a 2-flop synchroniser on each rising sclk and the transmit
// register shifts on each falling sclk. done pulses one cycle with rx valid.
module spi_master_byte
  import spi_dbg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  output logic [7:0] rx_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active_q, active_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  half_q, half_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  rx_q, rx_d;
  logic        done_q, done_d;
  logic        meta_q, sync_q;

  // Two-flop synchroniser on the asynchronous miso input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= miso_i;
      sync_q <= meta_q;
    end
  end

  // Divider and half-period sequencing: even halves sclk low, odd halves high.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    half_d   = half_q;
    sclk_d   = sclk_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        div_d    = '0;
        half_d   = '0;
        sclk_d   = 1'b0;
        sr_d     = tx_i;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (half_q == 4'd15) begin
        // Last falling edge: byte complete, mosi parks low.
        active_d = 1'b0;
        sclk_d   = 1'b0;
        sr_d     = '0;
        done_d   = 1'b1;
      end else begin
        half_d = half_q + 4'd1;
        sclk_d = ~sclk_q;
        if (!half_q[0]) begin
          rx_d = {rx_q[6:0], sync_q};
        end else begin
          sr_d = {sr_q[6:0], 1'b0};
        end
      end
    end else begin
      div_d = div_q + 16'd1;
    end
  end

  // Byte engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
      sr_q     <= '0;
      rx_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sclk_q   <= sclk_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
    end
  end

  assign rx_o   = rx_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = sr_q[7];

endmodule

// File: rtl/spi_dbg_host.sv
// Host-side initiator for the debug SPI READ command. Sequences CMD, three
// address bytes, readiness polling and the data byte over spi_master_byte,
// owning ss_n and the request/response handshake. The slave's reply to a
// byte arrives during the following byte, so each state judges the byte it
// receives as the answer to the previous one.
// Build option: define SPI_DBG_TIMEOUT_EN to bound polling at POLL_MAX
// consecutive non-ready replies and report rsp_err.
module spi_dbg_host
  import spi_dbg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int POLL_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);

  localparam logic [15:0] LEAD_CNT = 16'(CLK_DIV);
  localparam logic [15:0] GAP_CNT  = 16'(GAP_CYCLES);
  localparam logic [15:0] HOLD_CNT = 16'(2 * CLK_DIV);

  logic [2:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] hold_q, hold_d;
  logic        infl_q, infl_d;
  logic        first_q, first_d;
  logic        ss_n_q, ss_n_d;
  logic        ready_q, ready_d;
  logic        pend_q, pend_d;
  logic [7:0]  res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_tx;
  logic [7:0]  byte_rx;

`ifdef SPI_DBG_TIMEOUT_EN
  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
  logic [7:0] poll_cnt_q, poll_cnt_d;

  // Consecutive non-ready poll reply counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`else
  logic unused_poll_max;
  assign unused_poll_max = (POLL_MAX == 0);
`endif

  spi_master_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(byte_start),
    .tx_i   (byte_tx),
    .rx_o   (byte_rx),
    .done_o (byte_done),
    .sclk_o (sclk),
    .mosi_o (mosi),
    .miso_i (miso)
  );

  // Transaction sequencing, byte pacing and response staging.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    infl_d      = infl_q;
    first_d     = first_q;
    ss_n_d      = ss_n_q;
    pend_d      = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    rsp_valid_d = pend_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    byte_start  = 1'b0;
    byte_tx     = tx_byte(state_q, addr_q);
`ifdef SPI_DBG_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif
    if (pend_q) begin
      rsp_data_d = res_data_q;
      rsp_err_d  = res_err_q;
    end
    case (state_q)
      S_IDLE: begin
        if (hold_q != 16'd0) hold_d = hold_q - 16'd1;
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          ss_n_d  = 1'b0;
          wait_d  = LEAD_CNT;
          infl_d  = 1'b0;
          state_d = S_CMD;
        end
      end
      S_DONE: begin
        if (wait_q != 16'd0) begin
          wait_d = wait_q - 16'd1;
        end else begin
          ss_n_d  = 1'b1;
          pend_d  = 1'b1;
          hold_d  = HOLD_CNT;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!infl_q) begin
          if (wait_q != 16'd0) begin
            wait_d = wait_q - 16'd1;
          end else begin
            byte_start = 1'b1;
            infl_d     = 1'b1;
          end
        end else if (byte_done) begin
          infl_d = 1'b0;
          wait_d = GAP_CNT;
          case (state_q)
            S_CMD:   state_d = S_ADDR0;
            S_ADDR0: state_d = S_ADDR1;
            S_ADDR1: state_d = S_ADDR2;
            S_ADDR2: begin
              state_d = S_POLL;
              first_d = 1'b1;
`ifdef SPI_DBG_TIMEOUT_EN
              poll_cnt_d = '0;
`endif
            end
            S_POLL: begin
              if (first_q) begin
                first_d = 1'b0;
              end else if (byte_rx == RSP_READY) begin
                state_d = S_DATA;
              end else begin
`ifdef SPI_DBG_TIMEOUT_EN
                if (poll_cnt_q == POLL_LAST) begin
                  state_d    = S_DONE;
                  res_data_d = 8'h00;
                  res_err_d  = 1'b1;
                  wait_d     = LEAD_CNT;
                end else begin
                  poll_cnt_d = poll_cnt_q + 8'd1;
                end
`endif
              end
            end
            S_DATA: begin
              state_d    = S_DONE;
              res_data_d = byte_rx;
              res_err_d  = 1'b0;
              wait_d     = LEAD_CNT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    ready_d = (state_d == S_IDLE) && (hold_d == 16'd0);
  end

  // Host FSM and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wait_q      <= '0;
      hold_q      <= '0;
      infl_q      <= 1'b0;
      first_q     <= 1'b0;
      ss_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      pend_q      <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      infl_q      <= infl_d;
      first_q     <= first_d;
      ss_n_q      <= ss_n_d;
      ready_q     <= ready_d;
      pend_q      <= pend_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ss_n      = ss_n_q;
  assign busy      = (state_q != S_IDLE) | pend_q;

endmodule

// File: tb/tb_spi_dbg_host.sv
// Directed bench for spi_dbg_host with a behavioural mode-0 debug SPI slave.
module tb_spi_dbg_host;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int POLL_MAX   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        miso = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, busy, sclk, mosi, ss_n;
  logic [7:0]  rsp_data;

  int vec = 0;
  int err = 0;

  spi_dbg_host #(
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  // Cycle counter and bookkeeping
  int cyc = 0;
  int rsp_cnt = 0;
  int all_rises = 0;
  int ssn_falls = 0;
  int ssn_rise_cyc = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
  end
  always @(posedge sclk) all_rises = all_rises + 1;
  always @(posedge ss_n) ssn_rise_cyc = cyc;

  // Slave model: replies rep[k] during byte k, captures mosi bytes into got[k]
  logic [7:0] rep [0:63];
  logic [7:0] got [0:63];
  logic [7:0] shin = '0;
  int sbyte = 0, sbit = 0, rises = 0;
  int last_rise = 0, last_mosi_chg = 0, ssn_fall_cyc = 0, first_rise_cyc = -1;
  int min_setup = 1000, per_min = 1000, per_max = 0;

  always @(mosi) last_mosi_chg = cyc;

  always @(negedge ss_n) begin
    ssn_falls = ssn_falls + 1;
    sbyte = 0; sbit = 0; rises = 0;
    first_rise_cyc = -1; ssn_fall_cyc = cyc;
    min_setup = 1000; per_min = 1000; per_max = 0;
    miso = rep[0][7];
  end

  always @(posedge sclk) begin
    if (ss_n === 1'b0) begin
      if (sbit != 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
      if (cyc - last_mosi_chg < min_setup) min_setup = cyc - last_mosi_chg;
      last_rise = cyc;
      shin = {shin[6:0], mosi};
      sbit = sbit + 1;
      rises = rises + 1;
    end
  end

  always @(negedge sclk) begin
    int idx;
    if (ss_n === 1'b0) begin
      if (sbit == 8) begin
        if (sbyte < 64) got[sbyte] = shin;
        sbyte = sbyte + 1;
        sbit = 0;
      end
      idx = (sbyte < 64) ? sbyte : 63;
      miso = rep[idx][7 - sbit];
    end
  end

  task automatic clear_rep();
    for (int i = 0; i < 64; i++) begin
      rep[i] = 8'h00;
      got[i] = 8'h00;
    end
  endtask

  task automatic do_req(input logic [23:0] a);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    vec++;
    if (req_ready !== 1'b1) begin
      err++; $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
    end
    @(negedge clk); req_addr = a; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rcyc);
    int n;
    n = 0;
    rcyc = -1;
    while (n < 20000) begin
      @(posedge clk); #1; n++;
      if (rsp_valid === 1'b1) begin
        rcyc = cyc;
        break;
      end
    end
    vec++;
    if (rcyc < 0) begin
      err++; $display("FAIL rsp_wait: rsp_valid never seen, required a pulse");
    end
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (ss_n !== 1'b1) begin err++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
    vec++; if (sclk !== 1'b0) begin err++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    vec++; if (mosi !== 1'b0) begin err++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    vec++; if (req_ready !== 1'b0) begin err++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vec++; if (rsp_data !== 8'h00) begin err++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    vec++; if (rsp_err !== 1'b0) begin err++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0; #1;
    vec++; if (req_ready !== 1'b0) begin err++; $display("FAIL ready_at_release: got %b want 0", req_ready); end
    @(posedge clk); #1;
    vec++; if (req_ready !== 1'b1) begin err++; $display("FAIL ready_after_release: got %b want 1", req_ready); end
    r0 = all_rises;
    repeat (1000) @(posedge clk);
    #1;
    vec++; if (all_rises != r0) begin err++; $display("FAIL idle_sclk: %0d edges want 0", all_rises - r0); end
    vec++; if (ss_n !== 1'b1) begin err++; $display("FAIL idle_ss_n: got %b want 1", ss_n); end
  endtask

  task automatic test_basic_read();
    logic [7:0] exp [0:6];
    int rc, rdy;
    exp = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00};
    clear_rep();
    rep[1] = 8'h01; rep[2] = 8'h12; rep[3] = 8'h34; rep[4] = 8'h00;
    rep[5] = 8'hFF; rep[6] = 8'hA5;
    do_req(24'h123456);
    #1;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_rsp(rc);
    vec++; if (rsp_data !== 8'hA5) begin err++; $display("FAIL basic_data: got %h want a5", rsp_data); end
    vec++; if (rsp_err !== 1'b0) begin err++; $display("FAIL basic_err: got %b want 0", rsp_err); end
    vec++; if (rises != 56) begin err++; $display("FAIL basic_edges: got %0d want 56", rises); end
    vec++; if (sbyte != 7) begin err++; $display("FAIL basic_bytes: got %0d want 7", sbyte); end
    for (int i = 0; i < 7; i++) begin
      vec++;
      if (got[i] !== exp[i]) begin
        err++; $display("FAIL basic_mosi[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
    vec++; if (rc != ssn_rise_cyc + 1) begin err++; $display("FAIL rsp_lag: rsp at %0d want %0d", rc, ssn_rise_cyc + 1); end
    @(posedge clk); #1;
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL rsp_pulse: got %b want 0", rsp_valid); end
    vec++; if (rsp_data !== 8'hA5) begin err++; $display("FAIL rsp_hold: got %h want a5", rsp_data); end
    rdy = -1;
    for (int n = 0; n < 100; n++) begin
      if (req_ready === 1'b1) begin rdy = cyc; break; end
      @(posedge clk); #1;
    end
    vec++;
    if (rdy < 0 || rdy - ssn_rise_cyc < 2 * CLK_DIV) begin
      err++; $display("FAIL ready_holdoff: %0d cycles want >= %0d", rdy - ssn_rise_cyc, 2 * CLK_DIV);
    end
  endtask

  task automatic test_busy_polling();
    int rc;
    clear_rep();
    rep[4] = 8'h00;
    for (int i = 5; i < 15; i++) rep[i] = 8'hFE;
    rep[15] = 8'hFF; rep[16] = 8'h3C;
    do_req(24'hABCDEF);
    wait_rsp(rc);
    vec++; if (rsp_data !== 8'h3C) begin err++; $display("FAIL poll_data: got %h want 3c", rsp_data); end
    vec++; if (sbyte != 17) begin err++; $display("FAIL poll_bytes: got %0d want 17", sbyte); end
    vec++; if (rises != 136) begin err++; $display("FAIL poll_edges: got %0d want 136", rises); end
    vec++; if (got[3] !== 8'hEF) begin err++; $display("FAIL poll_addr2: got %h want ef", got[3]); end
    for (int i = 4; i < 17; i++) begin
      vec++;
      if (got[i] !== 8'h00) begin
        err++; $display("FAIL poll_mosi[%0d]: got %h want 00", i, got[i]);
      end
    end
  endtask

  task automatic test_mode0_timing();
    int rc;
    clear_rep();
    rep[5] = 8'hFF; rep[6] = 8'h5A;
    do_req(24'h00F0F0);
    wait_rsp(rc);
    vec++; if (rsp_data !== 8'h5A) begin err++; $display("FAIL timing_data: got %h want 5a", rsp_data); end
    vec++; if (per_min != 2 * CLK_DIV || per_max != 2 * CLK_DIV) begin
      err++; $display("FAIL sclk_period: min %0d max %0d want %0d", per_min, per_max, 2 * CLK_DIV);
    end
    vec++; if (min_setup < CLK_DIV) begin err++; $display("FAIL mosi_setup: got %0d want >= %0d", min_setup, CLK_DIV); end
    vec++; if (first_rise_cyc - ssn_fall_cyc < CLK_DIV) begin
      err++; $display("FAIL ss_lead: got %0d want >= %0d", first_rise_cyc - ssn_fall_cyc, CLK_DIV);
    end
  endtask

  task automatic test_reset_mid();
    int rc, r0, n;
    clear_rep();
    rep[5] = 8'hFF; rep[6] = 8'h99;
    do_req(24'h445566);
    n = 0;
    while (!(sbyte == 2 && sbit >= 3) && n < 3000) begin @(posedge clk); #1; n++; end
    vec++; if (sbyte != 2) begin err++; $display("FAIL mid_reach_addr1: byte %0d want 2", sbyte); end
    @(negedge clk);
    r0 = rsp_cnt;
    rst = 1'b1; #1;
    vec++; if (ss_n !== 1'b1) begin err++; $display("FAIL mid_ss_n: got %b want 1", ss_n); end
    vec++; if (sclk !== 1'b0) begin err++; $display("FAIL mid_sclk: got %b want 0", sclk); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    vec++; if (rsp_cnt != r0) begin err++; $display("FAIL mid_no_rsp: %0d pulses want 0", rsp_cnt - r0); end
    vec++; if (rsp_data !== 8'h00) begin err++; $display("FAIL mid_rsp_data: got %h want 00", rsp_data); end
    clear_rep();
    rep[5] = 8'hFF; rep[6] = 8'h77;
    do_req(24'h010203);
    wait_rsp(rc);
    vec++; if (rsp_data !== 8'h77) begin err++; $display("FAIL mid_recover_data: got %h want 77", rsp_data); end
    vec++; if (got[2] !== 8'h02) begin err++; $display("FAIL mid_recover_addr: got %h want 02", got[2]); end
  endtask

  task automatic test_ignore_busy();
    int rc, f0, n;
    clear_rep();
    rep[5] = 8'hFF; rep[6] = 8'h42;
    do_req(24'h111111);
    n = 0;
    while (sbyte < 1 && n < 2000) begin @(posedge clk); #1; n++; end
    @(negedge clk); req_addr = 24'h222222; req_valid = 1'b1;
    repeat (50) @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(rc);
    vec++; if (rsp_data !== 8'h42) begin err++; $display("FAIL ign_data: got %h want 42", rsp_data); end
    vec++; if (got[1] !== 8'h11) begin err++; $display("FAIL ign_addr: got %h want 11", got[1]); end
    f0 = ssn_falls;
    repeat (300) @(posedge clk);
    #1;
    vec++; if (ssn_falls != f0) begin err++; $display("FAIL ign_queued: %0d new transfers want 0", ssn_falls - f0); end
  endtask

`ifdef SPI_DBG_TIMEOUT_EN
  task automatic test_timeout();
    int rc;
    clear_rep();
    for (int i = 4; i < 64; i++) rep[i] = 8'hFE;
    rep[4] = 8'h00;
    do_req(24'h0A0B0C);
    wait_rsp(rc);
    vec++; if (rsp_err !== 1'b1) begin err++; $display("FAIL to_err: got %b want 1", rsp_err); end
    vec++; if (rsp_data !== 8'h00) begin err++; $display("FAIL to_data: got %h want 00", rsp_data); end
    vec++; if (sbyte != 9) begin err++; $display("FAIL to_bytes: got %0d want 9", sbyte); end
  endtask
`endif

  initial begin
    clear_rep();
    test_reset();
    test_basic_read();
    test_busy_polling();
    test_mode0_timing();
    test_reset_mid();
    test_ignore_busy();
`ifdef SPI_DBG_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
